// File: rtl/uart_tx_channel_scheduler.sv
//==============================================================================
// uart_tx_channel_scheduler
//   Round-robin, burst-capped sharing of one 8N1 UART TX line among NUM_CH
//   byte sources.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_channel_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int MAX_BURST    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req_valid,
  input  logic [NUM_CH*8-1:0]       req_data,
  output logic [NUM_CH-1:0]         req_ready,
  output logic                      uart_tx,
  output logic                      grant_active,
  output logic [$clog2(NUM_CH)-1:0] grant_ch,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        C_MAX_BURST = 4'(MAX_BURST);
  localparam logic [CH_W-1:0]   C_LAST_CH   = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [3:0]        burst_q;
  logic [7:0]        shift_q;
  logic [CH_W-1:0]   grant_q;
  logic [CH_W-1:0]   last_q;
  logic              tx_q;

  logic [7:0]        w_bytes [NUM_CH];
  logic [CH_W-1:0]   w_pick;
  logic              w_any;
  logic              w_baud_last;
  logic              w_accept_idle;
  logic              w_accept_stop;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign w_bytes[i] = req_data[8*i +: 8];
  end

  // Scan from farthest to nearest so the nearest valid channel after last_q wins.
  always_comb begin
    int idx;
    idx    = 0;
    w_pick = '0;
    w_any  = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req_valid[CH_W'(idx)]) begin
        w_pick = CH_W'(idx);
        w_any  = 1'b1;
      end
    end
  end

  assign w_baud_last   = (baud_q == C_BAUD_LAST);
  assign w_accept_idle = (state_q == S_IDLE) && w_any && !reset;
  assign w_accept_stop = (state_q == S_STOP) && w_baud_last && req_valid[grant_q] &&
                         (burst_q < C_MAX_BURST) && !reset;

  always_comb begin
    req_ready = '0;
    if (w_accept_idle)      req_ready[w_pick]  = 1'b1;
    else if (w_accept_stop) req_ready[grant_q] = 1'b1;
  end

  assign uart_tx      = tx_q;
  assign busy         = (state_q != S_IDLE);
  assign grant_active = busy || w_accept_idle;
  assign grant_ch     = w_accept_idle ? w_pick : grant_q;
  assign frame_done   = (state_q == S_STOP) && w_baud_last && !reset;

  // tx_q is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      burst_q <= '0;
      shift_q <= '0;
      grant_q <= '0;
      last_q  <= C_LAST_CH;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (w_accept_idle) begin
            shift_q <= w_bytes[w_pick];
            grant_q <= w_pick;
            burst_q <= 4'd1;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (w_baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_last) begin
            baud_q <= '0;
            if (w_accept_stop) begin
              shift_q <= w_bytes[grant_q];
              burst_q <= burst_q + 1'b1;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              last_q  <= grant_q;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_channel_scheduler.sv
//==============================================================================
// tb_uart_tx_channel_scheduler
//   Randomized and directed bench with a transaction-level scheduling model.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int CPB    = 16;
  localparam int MAXB   = 4;
  localparam int CH_W   = 2;
  localparam int FRAME  = 10 * CPB;
  localparam int MAXC   = 8192;
  localparam int MAXI   = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH*8-1:0]  req_data;
  logic [NUM_CH-1:0]    req_ready;
  logic                 uart_tx;
  logic                 grant_active;
  logic [CH_W-1:0]      grant_ch;
  logic                 frame_done;
  logic                 busy;

  uart_tx_channel_scheduler #(
    .NUM_CH       (NUM_CH),
    .CLKS_PER_BIT (CPB),
    .MAX_BURST    (MAXB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .uart_tx      (uart_tx),
    .grant_active (grant_active),
    .grant_ch     (grant_ch),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Stimulus items: per-channel FIFO order is item index order.
  int it_ch [MAXI];
  int it_dat[MAXI];
  int it_arr[MAXI];
  bit it_taken[MAXI];
  bit md[MAXI];
  int n_items;

  int ex_ch[MAXI], ex_dat[MAXI], ex_cyc[MAXI], ex_n;
  int ob_ch[MAXI], ob_dat[MAXI], ob_cyc[MAXI], ob_n;

  logic            rec_tx[MAXC], rec_fd[MAXC], rec_ga[MAXC], rec_busy[MAXC];
  logic [3:0]      rec_rdy[MAXC];
  logic [CH_W-1:0] rec_gch[MAXC];
  logic            exp_tx[MAXC], exp_fd[MAXC], exp_ga[MAXC], exp_busy[MAXC];
  logic [3:0]      exp_rdy[MAXC];
  logic [CH_W-1:0] exp_gch[MAXC];

  task automatic add_item(input int c, input int d, input int a);
    it_ch[n_items]  = c;
    it_dat[n_items] = d;
    it_arr[n_items] = a;
    n_items++;
  endtask

  function automatic int first_pending(input int c, input bit use_model);
    for (int i = 0; i < n_items; i++)
      if (it_ch[i] == c && !(use_model ? md[i] : it_taken[i])) return i;
    return -1;
  endfunction

  // Transaction-level schedule: round-robin grant, up to MAXB frames per grant
  // while the granted source has its next byte by the last stop cycle.
  task automatic run_model();
    int t, last, g, a, d, h, burst, remaining;
    bit more;
    for (int i = 0; i < MAXI; i++) md[i] = 1'b0;
    ex_n = 0; t = 0; last = NUM_CH - 1; remaining = n_items;
    while (remaining > 0 && t < MAXC - 2*FRAME) begin
      g = -1;
      for (int k = 1; k <= NUM_CH; k++) begin
        h = first_pending((last + k) % NUM_CH, 1'b1);
        if (g < 0 && h >= 0 && it_arr[h] <= t) g = (last + k) % NUM_CH;
      end
      if (g < 0) begin
        t++;
      end else begin
        a = t; burst = 0; more = 1'b1; d = t;
        while (more) begin
          h = first_pending(g, 1'b1);
          md[h] = 1'b1; remaining--;
          ex_ch[ex_n] = g; ex_dat[ex_n] = it_dat[h]; ex_cyc[ex_n] = a; ex_n++;
          burst++;
          d = a + FRAME;
          h = first_pending(g, 1'b1);
          if (h >= 0 && it_arr[h] <= d && burst < MAXB) a = d;
          else more = 1'b0;
        end
        last = g;
        t = d + 1;
      end
    end
  endtask

  task automatic build_expect(input int horizon);
    int a, c, bi;
    for (int cy = 0; cy < horizon; cy++) begin
      exp_tx[cy] = 1'b1; exp_fd[cy] = 1'b0; exp_ga[cy] = 1'b0;
      exp_busy[cy] = 1'b0; exp_rdy[cy] = '0; exp_gch[cy] = '0;
    end
    for (int i = 0; i < ex_n; i++) begin
      a = ex_cyc[i];
      exp_rdy[a] = 4'(1 << ex_ch[i]);
      exp_ga[a]  = 1'b1;
      exp_gch[a] = CH_W'(ex_ch[i]);
      for (int j = 0; j < FRAME; j++) begin
        c  = a + 1 + j;
        bi = j / CPB;
        exp_tx[c]   = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : 1'((ex_dat[i] >> (bi - 1)) & 1);
        exp_busy[c] = 1'b1;
        exp_ga[c]   = 1'b1;
        exp_gch[c]  = CH_W'(ex_ch[i]);
      end
      exp_fd[a + FRAME] = 1'b1;
    end
  endtask

  task automatic apply_reset(input bit check_values);
    reset = 1'b1; req_valid = '0; req_data = '0;
    repeat (3) @(posedge clk);
    if (check_values) begin
      @(negedge clk);
      check("reset/uart_tx", uart_tx, 1);
      check("reset/req_ready", req_ready, 0);
      check("reset/grant_active", grant_active, 0);
      check("reset/grant_ch", grant_ch, 0);
      check("reset/frame_done", frame_done, 0);
      check("reset/busy", busy, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_scenario(input string name);
    int horizon, h, mt, mr, mf, mg, mb, mc;
    run_model();
    horizon = 40;
    for (int i = 0; i < n_items; i++) if (it_arr[i] + 40 > horizon) horizon = it_arr[i] + 40;
    if (ex_n > 0 && ex_cyc[ex_n-1] + FRAME + 20 > horizon) horizon = ex_cyc[ex_n-1] + FRAME + 20;
    build_expect(horizon);
    apply_reset(1'b0);
    for (int i = 0; i < MAXI; i++) it_taken[i] = 1'b0;
    ob_n = 0;
    for (int cy = 0; cy < horizon; cy++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        h = first_pending(c, 1'b0);
        req_valid[c]       = (h >= 0) && (it_arr[h] <= cy);
        req_data[8*c +: 8] = (h >= 0) ? 8'(it_dat[h]) : 8'h00;
      end
      @(negedge clk);
      rec_tx[cy] = uart_tx; rec_fd[cy] = frame_done; rec_ga[cy] = grant_active;
      rec_busy[cy] = busy; rec_rdy[cy] = req_ready; rec_gch[cy] = grant_ch;
      for (int c = 0; c < NUM_CH; c++) begin
        if (req_valid[c] && req_ready[c] && ob_n < MAXI) begin
          h = first_pending(c, 1'b0);
          it_taken[h] = 1'b1;
          ob_ch[ob_n] = c; ob_dat[ob_n] = it_dat[h]; ob_cyc[ob_n] = cy; ob_n++;
        end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    check({name, "/n_accepts"}, ob_n, ex_n);
    for (int i = 0; i < ex_n && i < ob_n; i++) begin
      check({name, "/accept_cycle"}, ob_cyc[i], ex_cyc[i]);
      check({name, "/accept_ch"}, ob_ch[i], ex_ch[i]);
      check({name, "/accept_data"}, ob_dat[i], ex_dat[i]);
    end
    mt = 0; mr = 0; mf = 0; mg = 0; mb = 0; mc = 0;
    for (int cy = 0; cy < horizon; cy++) begin
      if (rec_tx[cy]   !== exp_tx[cy])   mt++;
      if (rec_rdy[cy]  !== exp_rdy[cy])  mr++;
      if (rec_fd[cy]   !== exp_fd[cy])   mf++;
      if (rec_ga[cy]   !== exp_ga[cy])   mg++;
      if (rec_busy[cy] !== exp_busy[cy]) mb++;
      if (exp_ga[cy] && rec_gch[cy] !== exp_gch[cy]) mc++;
    end
    check({name, "/tx_line_mismatches"}, mt, 0);
    check({name, "/req_ready_mismatches"}, mr, 0);
    check({name, "/frame_done_mismatches"}, mf, 0);
    check({name, "/grant_active_mismatches"}, mg, 0);
    check({name, "/busy_mismatches"}, mb, 0);
    check({name, "/grant_ch_mismatches"}, mc, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_frame();
    bit seen;
    n_items = 0;
    apply_reset(1'b0);
    req_valid = 4'b0001; req_data = '0; req_data[7:0] = 8'h3C;
    @(negedge clk);
    check("rstmid/first_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < FRAME + 20 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      tick();
    end
    check("rstmid/first_frame_done", seen, 1);
    // Priority now rotates past ch0, so ch1 must win over ch0.
    req_valid = 4'b0011; req_data[7:0] = 8'h11; req_data[15:8] = 8'h5A;
    @(negedge clk);
    check("rstmid/rotated_ready", req_ready, 4'b0010);
    tick(); req_valid = '0;
    repeat (69) tick();
    @(negedge clk);
    check("rstmid/bit3_level", uart_tx, 1);
    check("rstmid/busy_mid", busy, 1);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    check("rstmid/tx_after", uart_tx, 1);
    check("rstmid/ready_after", req_ready, 0);
    check("rstmid/grant_after", grant_active, 0);
    check("rstmid/busy_after", busy, 0);
    tick();
    req_valid = 4'b0011;
    @(negedge clk);
    check("rstmid/ch0_first_ready", req_ready, 4'b0001);
    check("rstmid/ch0_first_grant", grant_ch, 0);
    tick(); req_valid = '0;
  endtask

  initial begin
    int fd_cyc, s3_cyc, last_arr[NUM_CH];
    bit found;
    n_items = 0;
    apply_reset(1'b1);

    n_items = 0; add_item(0, 8'hA5, 1);
    run_scenario("single");
    fd_cyc = -1;
    for (int cy = 0; cy < 400; cy++) if (fd_cyc < 0 && rec_fd[cy] === 1'b1) fd_cyc = cy;
    check("single/frame_done_offset", fd_cyc - ob_cyc[0], FRAME);
    check("single/grant_released", rec_ga[fd_cyc + 1], 0);

    n_items = 0;
    for (int c = 0; c < NUM_CH; c++) add_item(c, 8'h10 + c, 1);
    for (int c = 0; c < NUM_CH; c++) add_item(c, 8'h20 + c, 700);
    run_scenario("round_robin");

    n_items = 0;
    for (int i = 0; i < 6; i++) add_item(1, 8'h30 + i, 1);
    add_item(2, 8'h40, 1);
    run_scenario("burst_cap");
    check("burst_cap/back_to_back", ob_cyc[3] - ob_cyc[0], 3 * FRAME);
    check("burst_cap/fifth_is_ch2", ob_ch[4], 2);

    n_items = 0; add_item(2, 8'h50, 1); add_item(3, 8'h51, 1);
    run_scenario("early_release");
    check("early_release/gap", ob_cyc[1] - ob_cyc[0], FRAME + 1);

    n_items = 0;
    for (int i = 0; i < 10; i++) add_item(0, 8'h60 + i, 1);
    add_item(3, 8'h77, 200);
    run_scenario("starvation");
    found = 1'b0; s3_cyc = 0;
    for (int i = 0; i < ob_n; i++) if (!found && ob_ch[i] == 3) begin found = 1'b1; s3_cyc = ob_cyc[i]; end
    check("starvation/ch3_served", found, 1);
    check("starvation/bound", (s3_cyc - 200) <= MAXB * FRAME + 1, 1);

    for (int s = 0; s < 3; s++) begin
      n_items = 0;
      for (int c = 0; c < NUM_CH; c++) last_arr[c] = 1;
      for (int i = 0; i < $urandom_range(5, 10); i++) begin
        int c;
        c = $urandom_range(0, NUM_CH - 1);
        last_arr[c] = last_arr[c] + $urandom_range(0, 300);
        add_item(c, $urandom_range(0, 255), last_arr[c]);
      end
      run_scenario($sformatf("random%0d", s));
    end

    reset_mid_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
